// File: rtl/widths_struct_stream.sv
// Buffered two-field stream: stores {a, b, swap} words in a circular FIFO and
// re-emits each word packed as {a, b} or {b, a} according to its stored swap bit.
module widths_struct_stream #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [A_W+B_W-1:0]     in_flat,
  input  logic                   in_swap,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [A_W+B_W-1:0]     out_flat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned W     = A_W + B_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           swap;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt_q;
  logic               push;
  logic               pop;

  // Flags derive only from registered occupancy; flush masks both transfers.
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign count     = cnt_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a:    in_flat[W-1:B_W],
                       b:    in_flat[B_W-1:0],
                       swap: in_swap};
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_flat = '0;
    if (out_valid) begin
      out_flat = head.swap ? W'({head.b, head.a}) : W'({head.a, head.b});
    end
  end

endmodule

// File: tb/tb_widths_struct_stream.sv
// Scoreboard bench: directed vectors on the default configuration plus a random
// run on a narrow A_W=1/B_W=13/DEPTH=2 instance.
module tb_widths_struct_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_flat;
  logic        in_swap;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_flat;
  logic [2:0]  count;

  logic        rst1_n;
  logic        r_in_valid;
  logic        r_in_ready;
  logic [13:0] r_in_flat;
  logic        r_in_swap;
  logic        r_flush;
  logic        r_out_valid;
  logic        r_out_ready;
  logic [13:0] r_out_flat;
  logic [1:0]  r_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [11:0] q0[$];
  logic [13:0] q1[$];
  logic [11:0] mexp0;
  logic [13:0] mexp1;
  logic        done1 = 1'b0;

  widths_struct_stream #(.A_W(8), .B_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_flat(in_flat), .in_swap(in_swap), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat),
    .count(count)
  );

  widths_struct_stream #(.A_W(1), .B_W(13), .DEPTH(2)) dut_narrow (
    .clk(clk), .rst_n(rst1_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .in_flat(r_in_flat), .in_swap(r_in_swap), .flush(r_flush),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_flat(r_out_flat),
    .count(r_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] pack0(input logic [11:0] f, input logic s);
    return s ? {f[3:0], f[11:4]} : f;
  endfunction

  function automatic logic [13:0] pack1(input logic [13:0] f, input logic s);
    return s ? {f[12:0], f[13]} : f;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present a word and hold it until accepted; record its expected output on acceptance.
  task automatic send(input logic [11:0] f, input logic s, input logic [11:0] e);
    in_valid = 1'b1;
    in_flat  = f;
    in_swap  = s;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q0.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: got in_ready=0 expected acceptance of %h", f);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (count == 3'd0) break;
    end
    chk("drain_count", 32'(count), 32'd0);
    @(posedge clk); #1;
  endtask

  // Output monitor for the default instance.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL sb0_unexpected: got %h expected no word", out_flat);
      end else begin
        mexp0 = q0.pop_front();
        if (out_flat !== mexp0) begin
          failures++;
          $display("FAIL sb0_word: got %h expected %h", out_flat, mexp0);
        end
      end
    end
  end

  // Output monitor for the narrow instance.
  always @(negedge clk) begin
    if (rst1_n && r_out_valid && r_out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL sb1_unexpected: got %h expected no word", r_out_flat);
      end else begin
        mexp1 = q1.pop_front();
        if (r_out_flat !== mexp1) begin
          failures++;
          $display("FAIL sb1_word: got %h expected %h", r_out_flat, mexp1);
        end
      end
    end
  end

  // Random stimulus on the narrow instance.
  initial begin
    rst1_n = 1'b0; r_in_valid = 1'b0; r_in_flat = '0; r_in_swap = 1'b0;
    r_flush = 1'b0; r_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst1_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      r_in_valid  = 1'($urandom_range(0, 1));
      r_in_flat   = 14'($urandom);
      r_in_swap   = 1'($urandom_range(0, 1));
      r_out_ready = (i < 200) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (r_in_valid && r_in_ready) q1.push_back(pack1(r_in_flat, r_in_swap));
    end
    @(posedge clk); #1;
    chk("sb1_outstanding", 32'(q1.size()), 32'(r_count));
    r_in_valid  = 1'b0;
    r_out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    chk("narrow_count", 32'(r_count), 32'd0);
    done1 = 1'b1;
  end

  // Directed sequence on the default instance.
  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_flat = '0; in_swap = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_flat", 32'(out_flat), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic transfer, one-cycle latency.
    out_ready = 1'b1;
    send(12'hA53, 1'b0, 12'hA53);
    in_valid = 1'b0;
    @(negedge clk);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_flat", 32'(out_flat), 32'hA53);
    chk("basic_count", 32'(count), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pop_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // Swap ordering and interleaving.
    send(12'hA53, 1'b1, 12'h3A5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("swap_flat", 32'(out_flat), 32'h3A5);
    @(posedge clk); #1;
    send(12'hA53, 1'b0, 12'hA53);
    send(12'h5C7, 1'b1, 12'h75C);
    send(12'h0F1, 1'b0, 12'h0F1);
    send(12'hB2E, 1'b1, 12'hEB2);
    in_valid = 1'b0;
    wait_empty();

    // Fill under back-pressure, hold off the fifth word.
    out_ready = 1'b0;
    send(12'h123, 1'b0, 12'h123);
    send(12'h456, 1'b1, 12'h645);
    send(12'h789, 1'b0, 12'h789);
    send(12'hABC, 1'b1, 12'hCAB);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_head", 32'(out_flat), 32'h123);
    @(posedge clk); #1;
    in_valid = 1'b1; in_flat = 12'hDEF; in_swap = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("held_off_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    chk("full_pop_count", 32'(count), 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fifth_in_ready", 32'(in_ready), 32'd1);
    chk("after_pop_count", 32'(count), 32'd3);
    if (in_ready) q0.push_back(12'hDEF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty();

    // Steady push+pop at count 2 across pointer wrap.
    out_ready = 1'b0;
    send(12'h321, 1'b0, 12'h321);
    send(12'h654, 1'b1, 12'h465);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_flat   = 12'h0A0 + 12'(i * 37);
      in_swap   = 1'(i % 2);
      out_ready = 1'b1;
      @(negedge clk);
      chk("steady_count", 32'(count), 32'd2);
      if (in_ready) q0.push_back(pack0(in_flat, in_swap));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_empty();

    // Flush with a concurrent push, then asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(12'h111, 1'b0, 12'h111);
    send(12'h222, 1'b0, 12'h222);
    send(12'h333, 1'b0, 12'h333);
    in_flat = 12'h444; in_swap = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("preflush_count", 32'(count), 32'd3);
    chk("preflush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(12'h5A1, 1'b1, 12'h15A);
    send(12'h777, 1'b0, 12'h777);
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill_count", 32'(count), 32'd2);
    chk("refill_head", 32'(out_flat), 32'h15A);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_flat", 32'(out_flat), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    q0.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(12'h9C3, 1'b1, 12'h39C);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_flat", 32'(out_flat), 32'h39C);
    @(posedge clk); #1;
    wait_empty();

    wait (done1);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/widths_struct_stream.md
# widths_struct_stream

Parametrised, buffered successor to the flat two-field struct wrapper. It accepts a flattened two-field word (`a` in the upper bits, `b` in the lower bits) on a valid/ready stream and stores it in a DEPTH-entry FIFO. It re-emits each word as a flattened word, in either the original field order or swapped order, selected per word. The block sits between the fuzz stimulus driver and the DUT wrappers, so stimulus can be back-pressured and field ordering exercised without regenerating wrappers.

## Interface
- `A_W`, default 8: width of field `a`, ≥1.
- `B_W`, default 4: width of field `b`, ≥1.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: `in_flat` and `in_swap` are valid.
- `in_ready`, output, 1: FIFO can accept a word.
- `in_flat`, input, A_W+B_W: `a` in `[A_W+B_W-1:B_W]`, `b` in `[B_W-1:0]`.
- `in_swap`, input, 1: output ordering for this word.
- `flush`, input, 1: synchronous discard of all stored words.
- `out_valid`, output, 1: `out_flat` holds the head word.
- `out_ready`, input, 1: consumer accepts the head word.
- `out_flat`, output, A_W+B_W: packed head word.
- `count`, output, $clog2(DEPTH)+1: number of stored words.

## Operation
- Push occurs when `in_valid && in_ready`. The entry stores `a`, `b` and `in_swap`.
- Pop occurs when `out_valid && out_ready`.
- `out_flat` packing:
  - stored swap = 0: `{a, b}`.
  - stored swap = 1: `{b, a}`, i.e. `b` in `[A_W+B_W-1:A_W]` and `a` in `[A_W-1:0]`.
- Field values are never altered; only their position changes.
- Storage: circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap DEPTH-1 → 0. `count` tracks occupancy from 0 to DEPTH.
- Derived outputs:
  - `in_ready = (count != DEPTH)`.
  - `out_valid = (count != 0)`.
  - `out_flat` is driven from the head entry. When empty, `out_flat` = 0.
- Simultaneous push and pop:
  - When neither full nor empty: both occur and `count` is unchanged.
  - When full: `in_ready` = 0, so only the pop occurs. There is no same-cycle pass-through into a full FIFO.
  - When empty: only the push occurs. There is no bypass from input to output.
- `flush` = 1:
  - Both pointers and `count` go to 0 at the next edge.
  - Any push or pop in that cycle is ignored; the word is dropped.
  - `in_ready` is still computed from the pre-flush `count`.
- Reset (`rst_n` low, at any time including mid-stream):
  - Immediately sets pointers and `count` to 0.
  - Outputs take their reset values: `in_ready` = 1, `out_valid` = 0, `out_flat` = 0, `count` = 0.
  - Storage contents need not be cleared.
- Stream rules:
  - The consumer may hold `out_ready` low indefinitely; the head word and `out_valid` stay stable until popped or flushed.
  - The producer may drop `in_valid` at any time.

## Timing
- Latency: a word pushed at edge N appears on `out_flat` with `out_valid` = 1 after edge N, when the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: one word per cycle sustained when `out_ready` = 1 continuously.
- All outputs are combinational from registered state only. There is no combinational path from `in_*` or `out_ready` to any output.
- `count` and the flags update on the same edge as the push or pop that causes them.
- Reset deassertion is synchronised externally. The first push may occur on the first edge with `rst_n` high.

## Test plan
- Reset and basic transfer (A_W=8, B_W=4): push `12'hA53` with swap = 0.
  - After 1 edge: `out_valid` = 1, `out_flat` = `12'hA53`.
  - Pop leaves `count` = 0.
- Swap ordering: push `12'hA53` with swap = 1 → `out_flat` = `12'h3A5`.
  - Interleave swap = 0/1 over 4 words; each word is reordered independently.
- Full and back-pressure (DEPTH=4): hold `out_ready` = 0 and push 5 words.
  - After the 4th push: `in_ready` = 0, `count` = 4.
  - The 5th word is held off and not lost.
  - With `out_ready` = 1: words drain in order; the 5th is accepted on the cycle after the first pop.
- Simultaneous push/pop at `count` = 2 for 10 cycles:
  - `count` stays 2.
  - Output order matches input order across pointer wrap-around.
- Flush and reset mid-stream:
  - At `count` = 3, assert `flush` together with a push → next cycle `count` = 0, `out_valid` = 0.
  - Refill to 2, then pulse `rst_n` low between edges → `count` = 0, `out_flat` = 0 asynchronously.
- Parameter sweep at A_W=1, B_W=13, DEPTH=2 with random stimulus:
  - Scoreboard confirms packing matches the stored swap bit.
  - Scoreboard confirms no loss or duplication.
